cpu_fetch_sequencer: RTL
========================

// Module: cpu_fetch_sequencer
// PURPOSE
//  Sequences cpu_core: fetches 16-bit instructions from instruction memory via req/valid handshake,
//  presents each to the core for exactly one clock (one register-file write), then advances the PC.
//  Sits between instruction memory and cpu_core.instruction; drives a non-writing bubble otherwise.
//  Stops on a HALT opcode or on a fetch timeout; restarted by start.
// PARAMETERS
//  ADDR_W    8   instruction address / PC width
//  START_PC  0   PC loaded on start (ADDR_W bits)
//  MAX_WAIT  15  max cycles imem_req may stay unanswered before timeout (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       begin execution at START_PC; honoured only in IDLE or HALTED
//  imem_req     out  1       fetch request; held high with stable imem_addr until imem_valid
//  imem_addr    out  ADDR_W  fetch address (= PC)
//  imem_rdata   in   16      instruction data, sampled when imem_valid=1 while imem_req=1
//  imem_valid   in   1       fetch acknowledge; ignored when imem_req=0
//  instr_out    out  16      to cpu_core.instruction; NOP_INSTR unless issue=1
//  issue        out  1       one-cycle strobe: instr_out holds a real instruction this cycle
//  pc_out       out  ADDR_W  current PC
//  busy         out  1       high in FETCH or ISSUE
//  halted       out  1       high in HALTED
//  err          out  1       fetch timeout occurred; cleared by start
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=START_PC, imem_req=0, issue=0, instr_out=NOP_INSTR,
//   busy=0, halted=0, err=0, wait counter=0. Reset mid-fetch drops imem_req at once.
//  NOP_INSTR=16'hF800 (opcode 6'b111110: core writes nothing). HALT opcode = instr[15:10]=6'b111111.
//  All outputs registered. States: IDLE, FETCH, ISSUE, HALTED.
//  IDLE:   start=1 -> FETCH, pc<=START_PC.
//  FETCH:  imem_req=1, imem_addr=pc. imem_valid=1 -> capture imem_rdata;
//           opcode==HALT -> HALTED (no issue, pc unchanged); else -> ISSUE.
//           Wait counter increments each FETCH cycle without valid; reaching MAX_WAIT -> HALTED, err<=1.
//           imem_valid on the first FETCH cycle is legal (zero-wait memory).
//  ISSUE:  issue=1 and instr_out=captured word for exactly 1 cycle; pc<=pc+1 (wraps 2^ADDR_W-1 -> 0);
//           wait counter cleared; -> FETCH. Peak rate: 1 instruction per 2 cycles.
//  HALTED: halted=1, imem_req=0; start=1 -> FETCH, pc<=START_PC, err<=0.
//  start in FETCH/ISSUE ignored. imem_valid during IDLE/ISSUE/HALTED ignored.
//  Timeout on the same cycle as imem_valid: valid wins (no err).
// CONFIGURATION
//  SEQ_RETIRE_CNT_EN defined: extra port retire_cnt out 16, +1 on every issue=1 cycle, saturates
//   at 16'hFFFF, reset to 0, cleared on accepted start.
//  Undefined: retire_cnt port and its logic absent; all other behaviour identical.
// STRUCTURE
//  Package cpu_seq_pkg: seq_state_t enum {IDLE,FETCH,ISSUE,HALTED}, NOP_INSTR, HALT_OPCODE,
//   OPCODE_MSB/LSB (15/10) field constants.
//  Sub-module seq_wait_timer: MAX_WAIT counter with clear/enable inputs, timeout output.
// TESTING
//  1 Reset mid-FETCH with imem_req=1 -> imem_req=0 same cycle, instr_out=16'hF800, pc=START_PC.
//  2 start, zero-wait memory: ADD R1=R2+R3 (16'h0132), then HALT 16'hFC00 -> one issue,
//     core R1=12, halted=1 with pc=1, err=0.
//  3 imem_valid delayed 3 cycles -> imem_req/imem_addr stable throughout; single issue pulse.
//  4 No imem_valid for MAX_WAIT cycles -> halted=1, err=1; then start -> err=0, fetch at START_PC.
//  5 ADDR_W=2, 4 non-HALT words -> pc wraps 3->0, fetch continues at 0.
//  6 start pulsed during FETCH/ISSUE -> ignored; with SEQ_RETIRE_CNT_EN, 3 issues -> retire_cnt=3.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and instruction-field constants for the fetch sequencer.
// Optional feature macro used by the sequencer: SEQ_RETIRE_CNT_EN.
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam logic [15:0] NOP_INSTR   = 16'hF800;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;
  localparam int          OPCODE_MSB  = 15;
  localparam int          OPCODE_LSB  = 10;

  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts unanswered fetch cycles; timeout flags the cycle whose increment would reach MAX_WAIT.
module seq_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int              CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: cleared outside FETCH, advances on every cycle without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = en && (cnt_r == LAST);

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// Fetch/issue sequencer feeding cpu_core one instruction per handshake; halts on HALT or timeout.
// Optional retire counter port enabled by defining SEQ_RETIRE_CNT_EN.
module cpu_fetch_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] START_PC = {ADDR_W{1'b0}},
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [15:0]       instr_out,
  output logic              issue,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic              err
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  seq_state_t        state_r, next_state_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic              start_ok_s, timeout_s, wait_clr_s, wait_en_s;
  logic              req_nxt_s, issue_nxt_s, busy_nxt_s, halted_nxt_s, err_nxt_s;
  logic [15:0]       instr_nxt_s;

  assign start_ok_s = start && ((state_r == IDLE) || (state_r == HALTED));
  assign wait_clr_s = (state_r != FETCH);
  assign wait_en_s  = (state_r == FETCH) && !imem_valid;

  seq_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr_s),
    .en      (wait_en_s),
    .timeout (timeout_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a response in the timeout cycle takes priority over the timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = FETCH;
        else       next_state_s = IDLE;
      end
      FETCH: begin
        if (imem_valid) begin
          if (is_halt(imem_rdata)) next_state_s = HALTED;
          else                     next_state_s = ISSUE;
        end else if (timeout_s) begin
          next_state_s = HALTED;
        end else begin
          next_state_s = FETCH;
        end
      end
      ISSUE:   next_state_s = FETCH;
      HALTED: begin
        if (start) next_state_s = FETCH;
        else       next_state_s = HALTED;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every port comes straight from a flop
  always_comb begin
    req_nxt_s    = (next_state_s == FETCH);
    issue_nxt_s  = (next_state_s == ISSUE);
    busy_nxt_s   = (next_state_s == FETCH) || (next_state_s == ISSUE);
    halted_nxt_s = (next_state_s == HALTED);
    instr_nxt_s  = NOP_INSTR;
    err_nxt_s    = err;
    pc_nxt_s     = pc_r;
    if (issue_nxt_s) begin
      instr_nxt_s = imem_rdata;
    end else begin
      instr_nxt_s = NOP_INSTR;
    end
    if (start_ok_s) begin
      err_nxt_s = 1'b0;
    end else if ((state_r == FETCH) && !imem_valid && timeout_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err;
    end
    if (start_ok_s) begin
      pc_nxt_s = START_PC;
    end else if (state_r == ISSUE) begin
      pc_nxt_s = pc_r + ADDR_W'(1);
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Output and PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req  <= 1'b0;
      issue     <= 1'b0;
      instr_out <= NOP_INSTR;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      pc_r      <= START_PC;
    end else begin
      imem_req  <= req_nxt_s;
      issue     <= issue_nxt_s;
      instr_out <= instr_nxt_s;
      busy      <= busy_nxt_s;
      halted    <= halted_nxt_s;
      err       <= err_nxt_s;
      pc_r      <= pc_nxt_s;
    end
  end

  assign imem_addr = pc_r;
  assign pc_out    = pc_r;

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt_r;

  // Saturating count of issued instructions, restarted with each accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_r <= 16'h0000;
    end else if (start_ok_s) begin
      retire_cnt_r <= 16'h0000;
    end else if (issue && (retire_cnt_r != 16'hFFFF)) begin
      retire_cnt_r <= retire_cnt_r + 16'h0001;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
`endif

endmodule
